// File: rtl/writeback_unit_pkg.sv
// Shared CPU definitions for the write-back path: FSM encoding and register-bank geometry.
package writeback_unit_pkg;

  localparam int unsigned NumRegs        = 16;
  localparam int unsigned RegAddrW       = 4;
  localparam int unsigned DefaultTimeout = 255;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMemWait = 2'd1,
    StWrite   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of the retire, memory-read, register-bank and hazard-lookup signals.
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [RegAddrW-1:0] in_dest;
  logic                in_we;
  logic                in_we_high;
  logic                in_is_load;
  logic [31:0]         in_data;
  logic [31:0]         in_mem_addr;

  logic                mem_start;
  logic [31:0]         mem_addr;
  logic                mem_done;
  logic [31:0]         mem_q;

  logic                wb_en;
  logic                wb_we;
  logic                wb_we_high;
  logic                wb_read_mem;
  logic [RegAddrW-1:0] wb_addr_d;
  logic [31:0]         wb_data_d;
  logic [31:0]         wb_mem_q;

  logic [RegAddrW-1:0] haz_addr_a;
  logic [RegAddrW-1:0] haz_addr_b;
  logic                haz_a;
  logic                haz_b;
  logic                timeout_err;

  // Driver side: retiring core, memory responder and operand-fetch stage.
  modport master (
    output in_valid, in_dest, in_we, in_we_high, in_is_load, in_data, in_mem_addr,
    output mem_done, mem_q, haz_addr_a, haz_addr_b,
    input  in_ready, mem_start, mem_addr,
    input  wb_en, wb_we, wb_we_high, wb_read_mem, wb_addr_d, wb_data_d, wb_mem_q,
    input  haz_a, haz_b, timeout_err
  );

  // Write-back unit side.
  modport slave (
    input  in_valid, in_dest, in_we, in_we_high, in_is_load, in_data, in_mem_addr,
    input  mem_done, mem_q, haz_addr_a, haz_addr_b,
    output in_ready, mem_start, mem_addr,
    output wb_en, wb_we, wb_we_high, wb_read_mem, wb_addr_d, wb_data_d, wb_mem_q,
    output haz_a, haz_b, timeout_err
  );

endinterface

// File: rtl/writeback_unit_scoreboard.sv
// Pending-write bitmap: one bit per register, set on accept, cleared when the write
// lands or is abandoned. Register 0 is never tracked.
module wb_scoreboard
  import writeback_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [RegAddrW-1:0] set_addr,
  input  logic                clr_en,
  input  logic [RegAddrW-1:0] clr_addr,
  input  logic [RegAddrW-1:0] look_addr_a,
  input  logic [RegAddrW-1:0] look_addr_b,
  output logic                hit_a,
  output logic                hit_b
);

  logic [NumRegs-1:0] pending_q;
  logic [NumRegs-1:0] pending_d;

  // Next bitmap: clear first so a same-cycle set of a different register survives.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) pending_d[set_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Bitmap register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign hit_a = pending_q[look_addr_a];
  assign hit_b = pending_q[look_addr_b];

endmodule

// File: rtl/writeback_unit.sv
// Write-side sequencer for the register bank: accepts one retiring result, runs the
// memory read for loads, then emits a single-cycle write-back strobe.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave bus
);

  localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

  wb_state_e           state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                is_load_q, is_load_d;
  logic                we_high_q, we_high_d;
  logic [RegAddrW-1:0] addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_q_q, mem_q_d;
  logic                mem_start_q, mem_start_d;
  logic                wb_en_q, wb_en_d;
  logic                wb_we_high_q, wb_we_high_d;
  logic                wb_read_mem_q, wb_read_mem_d;
  logic                timeout_q, timeout_d;
  logic                set_en, clr_en;

  // Next-state and next-output logic; outputs are computed here and registered below.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_load_d     = is_load_q;
    we_high_d     = we_high_q;
    addr_d        = addr_q;
    data_d        = data_q;
    mem_addr_d    = mem_addr_q;
    mem_q_d       = mem_q_q;
    timeout_d     = timeout_q;
    mem_start_d   = 1'b0;
    wb_en_d       = 1'b0;
    wb_we_high_d  = 1'b0;
    wb_read_mem_d = 1'b0;
    set_en        = 1'b0;
    clr_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Results with in_we=0 are accepted and dropped without leaving IDLE.
        if (bus.in_valid && bus.in_we) begin
          addr_d    = bus.in_dest;
          we_high_d = bus.in_we_high;
          is_load_d = bus.in_is_load;
          data_d    = bus.in_data;
          set_en    = 1'b1;
          if (bus.in_is_load) begin
            mem_addr_d  = bus.in_mem_addr;
            mem_start_d = 1'b1;
            cnt_d       = '0;
            state_d     = StMemWait;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StMemWait: begin
        if (bus.mem_done) begin
          mem_q_d = bus.mem_q;
          cnt_d   = '0;
          state_d = StWrite;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          clr_en    = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWrite: begin
        clr_en  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StWrite) begin
      wb_en_d       = 1'b1;
      wb_we_high_d  = we_high_d & ~is_load_d;
      wb_read_mem_d = is_load_d;
    end
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      is_load_q     <= 1'b0;
      we_high_q     <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      mem_addr_q    <= '0;
      mem_q_q       <= '0;
      mem_start_q   <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_we_high_q  <= 1'b0;
      wb_read_mem_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_load_q     <= is_load_d;
      we_high_q     <= we_high_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      mem_addr_q    <= mem_addr_d;
      mem_q_q       <= mem_q_d;
      mem_start_q   <= mem_start_d;
      wb_en_q       <= wb_en_d;
      wb_we_high_q  <= wb_we_high_d;
      wb_read_mem_q <= wb_read_mem_d;
      timeout_q     <= timeout_d;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_en      (set_en),
    .set_addr    (bus.in_dest),
    .clr_en      (clr_en),
    .clr_addr    (addr_q),
    .look_addr_a (bus.haz_addr_a),
    .look_addr_b (bus.haz_addr_b),
    .hit_a       (bus.haz_a),
    .hit_b       (bus.haz_b)
  );

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.mem_start   = mem_start_q;
  assign bus.mem_addr    = mem_addr_q;
  // Only writing instructions ever reach WRITE, so the enable tracks the strobe.
  assign bus.wb_en       = wb_en_q;
  assign bus.wb_we       = wb_en_q;
  assign bus.wb_we_high  = wb_we_high_q;
  assign bus.wb_read_mem = wb_read_mem_q;
  assign bus.wb_addr_d   = addr_q;
  assign bus.wb_data_d   = data_q;
  assign bus.wb_mem_q    = mem_q_q;
  assign bus.timeout_err = timeout_q;

endmodule
